zxuno_textbank: RTL and testbench

- Parametrised bank of NSTR read-only text registers on the ZXUNO register port.
- Each string is LEN bytes and occupies one ZXUNO register address.
- Successive reads of a string's register return its bytes one per read access. Each string has its own auto-incrementing index.
- Adds three capabilities: multiple strings, selectable wrap or stop-at-end mode, and a write-to-seek.
- Sits beside the other ZXUNO register slaves. dout/oe feed the register read mux.

---
 rtl/zxuno_textbank.sv | 121 ++++++++++++
 tb/tb_zxuno_textbank.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/zxuno_textbank.sv
// zxuno_textbank: bank of NSTR read-only text registers on the ZXUNO register
// port. Each string sits at its own register address. Successive reads of that
// address return its bytes one per access, using a per-string index. An access
// ends on the first cycle after oe falls; only then does the index advance.
// A register write seeks the index. A write to the address port rewinds it.
module zxuno_textbank #(
  parameter int                    NSTR     = 2,
  parameter int                    LEN      = 16,
  parameter logic [7:0]            BASEADDR = 8'hFE,
  parameter logic [NSTR*LEN*8-1:0] STRINGS  = {"ZXUNO-CORE-ID...", "MEGA65-PORT....."},
  parameter bit                    WRAP     = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] zxuno_addr,
  input  logic       zxuno_regrd,
  input  logic       zxuno_regwr,
  input  logic [7:0] zxuno_din,
  input  logic       regaddr_changed,
  output logic [7:0] dout,
  output logic       oe
);

  localparam int IW = (LEN > 1) ? $clog2(LEN) : 1;

  logic [7:0]    sel;
  logic          hit;

  logic [IW-1:0] idx_q [NSTR];
  logic [IW-1:0] idx_d [NSTR];
  logic [NSTR-1:0] done_q, done_d;
  logic          reading_q, reading_d;
  logic [3:0]    rd_sel_q, rd_sel_d;
  logic [7:0]    dout_q, dout_d;

  // The seek data is only IW bits wide; the remaining din bits are don't-care.
  logic          din_unused;
  assign din_unused = ^zxuno_din;

  // Address decode. The unsigned 8-bit subtraction folds "below base" into
  // "too large", so one compare covers both sides of the window.
  assign sel = zxuno_addr - BASEADDR;
  assign hit = (sel < 8'(NSTR));
  assign oe  = hit & zxuno_regrd;
  assign dout = dout_q;

  // Next-state: read tracking, then advance, then seek, then rewind.
  // Later assignments override earlier ones, which gives the event priority.
  always_comb begin
    idx_d     = idx_q;
    done_d    = done_q;
    reading_d = reading_q;
    rd_sel_d  = rd_sel_q;

    if (oe) begin
      reading_d = 1'b1;
      rd_sel_d  = sel[3:0];
    end else if (reading_q) begin
      reading_d = 1'b0;
      for (int k = 0; k < NSTR; k++) begin
        if (rd_sel_q == 4'(k)) begin
          if (WRAP) begin
            idx_d[k] = idx_q[k] + IW'(1);
          end else if (!done_q[k]) begin
            if (idx_q[k] == IW'(LEN - 1)) begin
              done_d[k] = 1'b1;
            end else begin
              idx_d[k] = idx_q[k] + IW'(1);
            end
          end
        end
      end
    end

    for (int k = 0; k < NSTR; k++) begin
      if (hit && (sel == 8'(k))) begin
        if (zxuno_regwr) begin
          idx_d[k]  = zxuno_din[IW-1:0];
          done_d[k] = 1'b0;
        end
        if (regaddr_changed) begin
          idx_d[k]  = '0;
          done_d[k] = 1'b0;
          reading_d = 1'b0;
        end
      end
    end
  end

  // Read data: byte idx of the selected string, or zero when unselected or exhausted.
  always_comb begin
    dout_d = 8'h00;
    for (int k = 0; k < NSTR; k++) begin
      if (hit && (sel == 8'(k)) && !done_q[k]) begin
        dout_d = STRINGS[((NSTR - 1 - k) * LEN + (LEN - 1 - int'(idx_q[k]))) * 8 +: 8];
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NSTR; k++) begin
        idx_q[k] <= '0;
      end
      done_q    <= '0;
      reading_q <= 1'b0;
      rd_sel_q  <= 4'h0;
      dout_q    <= 8'h00;
    end else begin
      for (int k = 0; k < NSTR; k++) begin
        idx_q[k] <= idx_d[k];
      end
      done_q    <= done_d;
      reading_q <= reading_d;
      rd_sel_q  <= rd_sel_d;
      dout_q    <= dout_d;
    end
  end

endmodule

// File: tb/tb_zxuno_textbank.sv
// Scoreboard bench for zxuno_textbank. Instance A uses the default parameters
// (two 16-byte wrapping strings at FE/FF). Instance B is a single 4-byte
// stop-at-end string "AB\0C" at address 40 on the same bus. The driver pushes
// the expected {dout, oe} for each sample point; the monitor pops and compares
// on the falling clock edge whenever the driver flags a bus sample.
module tb_zxuno_textbank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] zxuno_addr;
  logic       zxuno_regrd;
  logic       zxuno_regwr;
  logic [7:0] zxuno_din;
  logic       regaddr_changed;
  logic [7:0] dout_a, dout_b;
  logic       oe_a, oe_b;

  always #5 clk = ~clk;

  zxuno_textbank u_a (
    .clk             (clk),
    .rst_n           (rst_n),
    .zxuno_addr      (zxuno_addr),
    .zxuno_regrd     (zxuno_regrd),
    .zxuno_regwr     (zxuno_regwr),
    .zxuno_din       (zxuno_din),
    .regaddr_changed (regaddr_changed),
    .dout            (dout_a),
    .oe              (oe_a)
  );

  zxuno_textbank #(
    .NSTR     (1),
    .LEN      (4),
    .BASEADDR (8'h40),
    .STRINGS  (32'h4142_0043),
    .WRAP     (1'b0)
  ) u_b (
    .clk             (clk),
    .rst_n           (rst_n),
    .zxuno_addr      (zxuno_addr),
    .zxuno_regrd     (zxuno_regrd),
    .zxuno_regwr     (zxuno_regwr),
    .zxuno_din       (zxuno_din),
    .regaddr_changed (regaddr_changed),
    .dout            (dout_b),
    .oe              (oe_b)
  );

  typedef struct {
    bit         inst;
    logic [7:0] dout;
    logic       oe;
    string      nm;
  } exp_t;

  exp_t  sb[$];
  logic  smp = 1'b0;
  int    vectors = 0;
  int    miscompares = 0;

  string s0 = "ZXUNO-CORE-ID...";

  // Monitor: at each flagged sample point compare the addressed instance.
  always @(negedge clk) begin
    if (smp) begin
      exp_t       e;
      logic [7:0] ad;
      logic       ao;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL sb_underflow: sample point with no expected entry");
      end else begin
        e  = sb.pop_front();
        ad = e.inst ? dout_b : dout_a;
        ao = e.inst ? oe_b : oe_a;
        if (ad !== e.dout || ao !== e.oe) begin
          miscompares++;
          $display("FAIL %s: got dout=%h oe=%b, want dout=%h oe=%b",
                   e.nm, ad, ao, e.dout, e.oe);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_push(input bit inst, input logic [7:0] d, input logic o, input string nm);
    exp_t e;
    e.inst = inst;
    e.dout = d;
    e.oe   = o;
    e.nm   = nm;
    sb.push_back(e);
  endtask

  // One read access: regrd high for two cycles, sampled on the second.
  // endact 1: rewind the same address in the cycle the access ends.
  // endact 2: seek FF to 2 in the cycle the access ends.
  task automatic rd(input logic [7:0] a, input bit inst, input logic [7:0] ed,
                    input logic eo, input string nm, input int endact);
    expect_push(inst, ed, eo, nm);
    zxuno_addr  = a;
    zxuno_regrd = 1'b1;
    tick();
    smp = 1'b1;
    tick();
    smp = 1'b0;
    zxuno_regrd = 1'b0;
    if (endact == 1) regaddr_changed = 1'b1;
    if (endact == 2) begin
      zxuno_addr  = 8'hFF;
      zxuno_din   = 8'h02;
      zxuno_regwr = 1'b1;
    end
    tick();
    regaddr_changed = 1'b0;
    zxuno_regwr     = 1'b0;
    tick();
  endtask

  task automatic rewind(input logic [7:0] a);
    zxuno_addr      = a;
    regaddr_changed = 1'b1;
    tick();
    regaddr_changed = 1'b0;
    tick();
  endtask

  task automatic seek(input logic [7:0] a, input logic [7:0] d);
    zxuno_addr  = a;
    zxuno_din   = d;
    zxuno_regwr = 1'b1;
    tick();
    zxuno_regwr = 1'b0;
    tick();
  endtask

  task automatic peek(input bit inst, input logic [7:0] d, input logic o, input string nm);
    expect_push(inst, d, o, nm);
    smp = 1'b1;
    tick();
    smp = 1'b0;
  endtask

  initial begin
    rst_n           = 1'b0;
    zxuno_addr      = 8'h00;
    zxuno_regrd     = 1'b0;
    zxuno_regwr     = 1'b0;
    zxuno_din       = 8'h00;
    regaddr_changed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    peek(1'b0, 8'h00, 1'b0, "reset_dout_a");
    peek(1'b1, 8'h00, 1'b0, "reset_dout_b");

    // Full pass through string 0, then wrap.
    rewind(8'hFE);
    for (int i = 0; i < 16; i++) begin
      rd(8'hFE, 1'b0, 8'(s0[i]), 1'b1, $sformatf("seq0_byte%0d", i), 0);
    end
    rd(8'hFE, 1'b0, "Z", 1'b1, "wrap_to_byte0", 0);

    // Per-string indices are independent.
    rewind(8'hFE);
    rewind(8'hFF);
    rd(8'hFE, 1'b0, "Z", 1'b1, "indep_fe0", 0);
    rd(8'hFE, 1'b0, "X", 1'b1, "indep_fe1", 0);
    rd(8'hFE, 1'b0, "U", 1'b1, "indep_fe2", 0);
    rd(8'hFF, 1'b1 ^ 1'b1, "M", 1'b1, "indep_ff0", 0);
    rd(8'hFF, 1'b0, "E", 1'b1, "indep_ff1", 0);
    rd(8'hFE, 1'b0, "N", 1'b1, "indep_fe3", 0);

    // Seek string 1 to byte 5 of "MEGA65-PORT.....".
    seek(8'hFF, 8'h25);
    rd(8'hFF, 1'b0, "5", 1'b1, "seek_ff_b5", 0);
    rd(8'hFF, 1'b0, "-", 1'b1, "seek_ff_b6", 0);

    // Stop-at-end string "AB\0C".
    rewind(8'h40);
    rd(8'h40, 1'b1, 8'h41, 1'b1, "nowrap_b0", 0);
    rd(8'h40, 1'b1, 8'h42, 1'b1, "nowrap_b1", 0);
    rd(8'h40, 1'b1, 8'h00, 1'b1, "nowrap_b2", 0);
    rd(8'h40, 1'b1, 8'h43, 1'b1, "nowrap_b3", 0);
    rd(8'h40, 1'b1, 8'h00, 1'b1, "nowrap_done5", 0);
    rd(8'h40, 1'b1, 8'h00, 1'b1, "nowrap_done6", 0);
    rewind(8'h40);
    rd(8'h40, 1'b1, 8'h41, 1'b1, "nowrap_rewound", 0);

    // Out-of-range addresses: no oe, zero data, no index movement.
    rd(8'h10, 1'b0, 8'h00, 1'b0, "oor_10", 0);
    rd(8'hFD, 1'b0, 8'h00, 1'b0, "oor_fd", 0);
    rd(8'hFE, 1'b0, "O", 1'b1, "oor_no_disturb", 0);

    // Seek ignores din bits above the index width.
    seek(8'hFE, 8'hF3);
    rd(8'hFE, 1'b0, "N", 1'b1, "seek_high_bits", 0);

    // Rewind colliding with the end of a read of the same string.
    rd(8'hFE, 1'b0, "O", 1'b1, "coll_rewind_rd", 1);
    // Seek of string 1 colliding with the end of a read of string 0.
    rd(8'hFE, 1'b0, "Z", 1'b1, "coll_after_rewind", 2);
    rd(8'hFF, 1'b0, "G", 1'b1, "coll_other_seek", 0);
    rd(8'hFE, 1'b0, "X", 1'b1, "coll_other_adv", 0);

    // Reset in the middle of a read.
    expect_push(1'b0, 8'h00, 1'b1, "rst_mid_read");
    zxuno_addr  = 8'hFE;
    zxuno_regrd = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    smp = 1'b1;
    tick();
    smp = 1'b0;
    zxuno_regrd = 1'b0;
    rst_n = 1'b1;
    tick();
    tick();
    rd(8'hFE, 1'b0, "Z", 1'b1, "rst_idx0", 0);
    rd(8'hFF, 1'b0, "M", 1'b1, "rst_idx1", 0);
    rd(8'h40, 1'b1, 8'h41, 1'b1, "rst_idx_b", 0);

    tick();
    tick();
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL sb_leftover: %0d entries unchecked, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
